// File: rtl/mult_pkg.sv
// Shared types for the sequential multiplier: FSM state encoding and step-counter sizing.
// No logic; no latency; no flow control.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter only has to reach WIDTH-1
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/addsub_n.sv
// Combinational WIDTH-bit adder/subtractor used once per multiply step.
// Zero latency; no flow control.
module addsub_n #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum
);

  assign sum = sub ? (a - b) : (a + b);

endmodule

// File: rtl/seq_multiplier_n.sv
// Shift-add multiplier, one multiplier bit per cycle, signed or unsigned operands.
// Out_valid rises WIDTH edges after accept; one operation in flight at a time.
// In_ready only while idle; the result is held in DONE until Out_ready or Abort.
module seq_multiplier_n
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               In_valid,
  output logic               In_ready,
  input  logic [WIDTH-1:0]   Opa,
  input  logic [WIDTH-1:0]   Opb,
  input  logic               Signed_mode,
  input  logic               Abort,
  output logic               Out_valid,
  input  logic               Out_ready,
  output logic [2*WIDTH-1:0] Product,
  output logic               Busy
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] s_q, a_q, b_q;
  logic             x_q, sgn_q;
  logic [CW-1:0]    cnt_q;
  logic             accept, last_step, step_sub;
  logic [WIDTH:0]   a_ext, s_ext, sum, xa;

  assign last_step = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    In_ready  = 1'b0;
    Busy      = 1'b0;
    Out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        In_ready = 1'b1;
        if (In_valid) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        Busy = 1'b1;
        if (Abort)          state_nxt = IDLE;
        else if (last_step) state_nxt = DONE;
      end
      DONE: begin
        Out_valid = 1'b1;
        if (Abort || Out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Signed mode subtracts the multiplicand on the MSB step (its weight is negative)
  assign a_ext    = sgn_q ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
  assign s_ext    = sgn_q ? {s_q[WIDTH-1], s_q} : {1'b0, s_q};
  assign step_sub = sgn_q & last_step;

  addsub_n #(
    .WIDTH(WIDTH + 1)
  ) u_addsub (
    .a  (a_ext),
    .b  (s_ext),
    .sub(step_sub),
    .sum(sum)
  );

  assign xa = b_q[0] ? sum : {x_q, a_q};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      x_q   <= 1'b0;
      sgn_q <= 1'b0;
      cnt_q <= '0;
    end else if (accept) begin
      s_q   <= Opa;
      b_q   <= Opb;
      a_q   <= '0;
      x_q   <= 1'b0;
      sgn_q <= Signed_mode;
      cnt_q <= '0;
    end else if (state == CALC && !Abort) begin
      // Right shift of {X,A,B}: X keeps its sign when signed, clears when unsigned
      x_q   <= sgn_q ? xa[WIDTH] : 1'b0;
      a_q   <= xa[WIDTH:1];
      b_q   <= {xa[0], b_q[WIDTH-1:1]};
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign Product = {a_q, b_q};

endmodule

// File: tb/tb_seq_multiplier_n.sv
// Bench for seq_multiplier_n at WIDTH=8 (cycle-checked against a transaction model) and WIDTH=16.
// Directed spot values, abort/reset cancellation, then randomized traffic.
module tb_seq_multiplier_n;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset_n;
  logic        in_valid8, abort8, out_ready8, smode8;
  logic [7:0]  opa8, opb8;
  logic        in_ready8, out_valid8, busy8;
  logic [15:0] prod8;

  logic        in_valid16, abort16, out_ready16, smode16;
  logic [15:0] opa16, opb16;
  logic        in_ready16, out_valid16, busy16;
  logic [31:0] prod16;

  int n_pass = 0;
  int n_total = 0;
  bit run_cmp = 1'b0;

  seq_multiplier_n #(.WIDTH(8)) dut8 (
    .Clk(Clk), .Reset_n(Reset_n), .In_valid(in_valid8), .In_ready(in_ready8),
    .Opa(opa8), .Opb(opb8), .Signed_mode(smode8), .Abort(abort8),
    .Out_valid(out_valid8), .Out_ready(out_ready8), .Product(prod8), .Busy(busy8)
  );

  seq_multiplier_n #(.WIDTH(16)) dut16 (
    .Clk(Clk), .Reset_n(Reset_n), .In_valid(in_valid16), .In_ready(in_ready16),
    .Opa(opa16), .Opb(opb16), .Signed_mode(smode16), .Abort(abort16),
    .Out_valid(out_valid16), .Out_ready(out_ready16), .Product(prod16), .Busy(busy16)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endtask

  // Reference product: interpret operands as w-bit numbers, multiply, keep 2w bits
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic s, input int w);
    longint sa, sb;
    logic [63:0] mask;
    sa = longint'({32'b0, a});
    sb = longint'({32'b0, b});
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 64'(sa * sb) & mask;
  endfunction

  // Transaction-level model of the 8-bit instance
  bit          m_calc = 1'b0;
  bit          m_done = 1'b0;
  int          m_left = 0;
  logic [15:0] m_exp = '0;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_calc <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
    end else if (!m_calc && !m_done) begin
      if (in_valid8) begin
        m_calc <= 1'b1;
        m_left <= 8;
        m_exp  <= 16'(ref_prod({24'b0, opa8}, {24'b0, opb8}, smode8, 8));
      end
    end else if (abort8) begin
      m_calc <= 1'b0;
      m_done <= 1'b0;
    end else if (m_calc) begin
      if (m_left == 1) begin
        m_calc <= 1'b0;
        m_done <= 1'b1;
      end
      m_left <= m_left - 1;
    end else if (out_ready8) begin
      m_done <= 1'b0;
    end
  end

  always @(negedge Clk) begin
    if (Reset_n && run_cmp) begin
      check("in_ready8", in_ready8, !m_calc && !m_done);
      check("busy8", busy8, m_calc);
      check("out_valid8", out_valid8, m_done);
      if (m_done) check("product8", prod8, m_exp);
    end
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input int hold, input logic [15:0] expv, input string nm);
    int lat;
    check({nm, "_rdy"}, in_ready8, 1);
    opa8 = a; opb8 = b; smode8 = s; in_valid8 = 1'b1; out_ready8 = 1'b0;
    @(posedge Clk); #1;
    in_valid8 = 1'b0; opa8 = 8'($urandom); opb8 = 8'($urandom); smode8 = 1'($urandom);
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      @(posedge Clk); #1;
      lat++;
    end
    check({nm, "_latency"}, lat, 8);
    check({nm, "_product"}, prod8, expv);
    repeat (hold) begin
      @(posedge Clk); #1;
      check({nm, "_hold_valid"}, out_valid8, 1);
      check({nm, "_hold_product"}, prod8, expv);
      check({nm, "_hold_in_ready"}, in_ready8, 0);
    end
    out_ready8 = 1'b1;
    @(posedge Clk); #1;
    out_ready8 = 1'b0;
    check({nm, "_after_valid"}, out_valid8, 0);
    check({nm, "_after_in_ready"}, in_ready8, 1);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic [31:0] expv, input string nm);
    int lat;
    check({nm, "_rdy"}, in_ready16, 1);
    opa16 = a; opb16 = b; smode16 = s; in_valid16 = 1'b1; out_ready16 = 1'b0;
    @(posedge Clk); #1;
    in_valid16 = 1'b0; opa16 = 16'($urandom); opb16 = 16'($urandom);
    lat = 0;
    while (!out_valid16 && lat < 60) begin
      @(posedge Clk); #1;
      lat++;
    end
    check({nm, "_latency"}, lat, 16);
    check({nm, "_product"}, prod16, expv);
    out_ready16 = 1'b1;
    @(posedge Clk); #1;
    out_ready16 = 1'b0;
    check({nm, "_after_valid"}, out_valid16, 0);
  endtask

  task automatic cancel_test(input bit use_reset, input string nm);
    bit seen;
    check({nm, "_rdy"}, in_ready8, 1);
    opa8 = 8'h3C; opb8 = 8'h5A; smode8 = 1'b0; in_valid8 = 1'b1;
    @(posedge Clk); #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    if (use_reset) begin
      Reset_n = 1'b0;
      #1;
      check({nm, "_async_in_ready"}, in_ready8, 1);
      check({nm, "_async_product"}, prod8, 0);
      check({nm, "_async_busy"}, busy8, 0);
      @(posedge Clk); #1;
      Reset_n = 1'b1;
    end else begin
      abort8 = 1'b1;
      @(posedge Clk); #1;
      abort8 = 1'b0;
      check({nm, "_in_ready"}, in_ready8, 1);
      check({nm, "_busy"}, busy8, 0);
    end
    seen = 1'b0;
    repeat (12) begin
      @(posedge Clk); #1;
      if (out_valid8) seen = 1'b1;
    end
    check({nm, "_no_out_valid"}, seen, 0);
  endtask

  initial begin
    logic [63:0] e;
    logic [15:0] ra, rb;
    logic        rs;
    Reset_n = 1'b0;
    in_valid8 = 0; abort8 = 0; out_ready8 = 0; smode8 = 0; opa8 = '0; opb8 = '0;
    in_valid16 = 0; abort16 = 0; out_ready16 = 0; smode16 = 0; opa16 = '0; opb16 = '0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_product8", prod8, 0);
    check("rst_in_ready8", in_ready8, 1);
    check("rst_out_valid8", out_valid8, 0);
    check("rst_busy8", busy8, 0);
    check("rst_product16", prod16, 0);
    check("rst_in_ready16", in_ready16, 1);
    Reset_n = 1'b1;
    run_cmp = 1'b1;

    check("model_7xfd", ref_prod(32'h07, 32'hFD, 1'b1, 8), 64'hFFEB);
    check("model_ffxff_u", ref_prod(32'hFF, 32'hFF, 1'b0, 8), 64'hFE01);
    check("model_8000x7fff", ref_prod(32'h8000, 32'h7FFF, 1'b1, 16), 64'hC0008000);

    @(posedge Clk); #1;
    op8(8'h07, 8'hFD, 1'b1, 0, 16'hFFEB, "s_07xfd");
    op8(8'h80, 8'h80, 1'b1, 0, 16'h4000, "s_80x80");
    op8(8'hFF, 8'hFF, 1'b1, 0, 16'h0001, "s_ffxff");
    op8(8'hFF, 8'hFF, 1'b0, 5, 16'hFE01, "u_ffxff_hold");
    cancel_test(1'b0, "abort_step3");
    op8(8'h05, 8'h03, 1'b0, 0, 16'h000F, "after_abort");
    cancel_test(1'b1, "reset_step3");
    op8(8'h05, 8'h03, 1'b0, 0, 16'h000F, "after_reset");

    op16(16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, "w16_8000x7fff");
    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      e = ref_prod({16'b0, ra}, {16'b0, rb}, rs, 16);
      op16(ra, rb, rs, e[31:0], "w16_rand");
    end

    for (int i = 0; i < 1500; i++) begin
      in_valid8  = 1'($urandom_range(0, 1));
      opa8       = 8'($urandom);
      opb8       = 8'($urandom);
      smode8     = 1'($urandom_range(0, 1));
      out_ready8 = 1'($urandom_range(0, 1));
      abort8     = ($urandom_range(0, 19) == 0);
      @(posedge Clk); #1;
    end
    in_valid8 = 1'b0; abort8 = 1'b0; out_ready8 = 1'b1;
    repeat (12) @(posedge Clk);
    #1;
    check("final_idle8", in_ready8, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
